// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer and its seven-segment display consumer.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        GO,
        DONE,
        FAIL
    } state_e;

    localparam logic [15:0] NO_RECORD = 16'hFFFF;
    localparam int          LFSR_W    = 16;

    // Fibonacci step, taps 16,14,13,11 (bit 16 is the MSB), shifting towards the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit LFSR; advances on every clock, regardless of game state.
module lfsr16
    import reaction_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign state = lfsr_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game controller: random wait, GO window, millisecond timing and best score.
// Outputs drive the seven-segment display directly; NO_RECORD marks an empty best score.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned       CYCLES_PER_MS = 100000,
    parameter int unsigned       MIN_DELAY_MS  = 1000,
    parameter int unsigned       MAX_TIME      = 9999,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    output logic        led_go,
    output logic        fail,
    output logic [15:0] current_time,
    output logic [15:0] best_time
);

    localparam int            PW         = $clog2(CYCLES_PER_MS);
    localparam int            DW         = $clog2(MIN_DELAY_MS + 4096);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_MS - 1);
    localparam logic [15:0]   TIME_LIMIT = 16'(MAX_TIME);

    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [DW-1:0]     delay_q, delay_d;
    logic [15:0]       cur_q, cur_d;
    logic [15:0]       best_q, best_d;
    logic              led_go_q, led_go_d;
    logic              fail_q, fail_d;
    logic              armed_q, armed_d;
    logic              btn_q;
    logic              press;
    logic              tick;
    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_unused;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    // Only the low 12 bits set the random delay.
    assign lfsr_unused = ^lfsr[LFSR_W-1:12];

    // armed_q blocks the edge from a button that was already held when reset released.
    assign press = btn & ~btn_q & armed_q;
    assign tick  = (state_q == WAIT || state_q == GO) && (presc_q == PRESC_LAST);

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        delay_d = delay_q;
        cur_d   = cur_q;
        best_d  = best_q;
        armed_d = armed_q | ~btn;

        case (state_q)
            IDLE, DONE, FAIL: begin
                if (press) begin
                    state_d = WAIT;
                    delay_d = DW'(MIN_DELAY_MS) + DW'(lfsr[11:0]);
                    cur_d   = '0;
                end
            end
            WAIT: begin
                if (press) begin
                    state_d = FAIL;
                end else if (tick) begin
                    if (delay_q == DW'(1)) begin
                        state_d = GO;
                        cur_d   = '0;
                    end else begin
                        delay_d = delay_q - DW'(1);
                    end
                end
            end
            GO: begin
                // A press wins over a same-cycle tick and keeps the un-incremented time.
                if (press) begin
                    state_d = DONE;
                    if (cur_q < best_q) best_d = cur_q;
                end else if (tick) begin
                    if (cur_q == TIME_LIMIT) state_d = FAIL;
                    else                     cur_d   = cur_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The prescaler restarts on every state change, so each phase is timed from its entry.
        if ((state_d == WAIT || state_d == GO) && state_d == state_q && !tick) begin
            presc_d = presc_q + PW'(1);
        end

        led_go_d = (state_d == GO);
        fail_d   = (state_d == FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            delay_q  <= '0;
            cur_q    <= '0;
            best_q   <= NO_RECORD;
            led_go_q <= 1'b0;
            fail_q   <= 1'b0;
            btn_q    <= 1'b0;
            armed_q  <= ~btn;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            delay_q  <= delay_d;
            cur_q    <= cur_d;
            best_q   <= best_d;
            led_go_q <= led_go_d;
            fail_q   <= fail_d;
            btn_q    <= btn;
            armed_q  <= armed_d;
        end
    end

    assign led_go       = led_go_q;
    assign fail         = fail_q;
    assign current_time = cur_q;
    assign best_time    = best_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: timestamp-based game model compared every cycle,
// plus hand-computed expectations at the key points of each directed scenario.
module tb_reaction_timer;

    localparam int unsigned CPM  = 4;
    localparam int unsigned MIND = 2;
    localparam int unsigned MAXT = 20;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef enum {P_IDLE, P_WAIT, P_GO, P_DONE, P_FAIL} phase_e;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b0;
    logic        led_go;
    logic        fail;
    logic [15:0] current_time;
    logic [15:0] best_time;

    int checks   = 0;
    int failures = 0;

    reaction_timer #(
        .CYCLES_PER_MS (CPM),
        .MIN_DELAY_MS  (MIND),
        .MAX_TIME      (MAXT),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
        .led_go       (led_go),
        .fail         (fail),
        .current_time (current_time),
        .best_time    (best_time)
    );

    always #5 clk = ~clk;

    // Game model: phase plus the cycle it was entered; times derive from elapsed cycles.
    phase_e      m_phase = P_IDLE;
    int unsigned cyc     = 0;
    int unsigned m_t0    = 0;
    int unsigned m_delay = 0;
    logic [15:0] m_cur   = 16'd0;
    logic [15:0] m_best  = 16'hFFFF;
    logic [15:0] m_lfsr  = SEED;
    logic        m_prev  = 1'b0;
    logic        m_hold  = 1'b0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] go_ms(input int unsigned c);
        int unsigned ms;
        ms = (c - m_t0) / CPM;
        if (ms > MAXT) ms = MAXT;
        return 16'(ms);
    endfunction

    task automatic enter_wait(input int unsigned c);
        m_phase = P_WAIT;
        m_t0    = c + 1;
        m_delay = MIND + int'(m_lfsr & 16'h0FFF);
        m_cur   = 16'd0;
    endtask

    task automatic model_step();
        int unsigned c;
        int unsigned in_phase;
        logic        pr;
        c = cyc;
        if (rst) begin
            m_phase = P_IDLE;
            m_cur   = 16'd0;
            m_best  = 16'hFFFF;
            m_lfsr  = SEED;
            m_prev  = 1'b0;
            m_hold  = btn;
        end else begin
            pr = btn && !m_prev && !m_hold;
            if (!btn) m_hold = 1'b0;
            in_phase = c - m_t0 + 1;
            case (m_phase)
                P_WAIT: begin
                    if (pr) begin
                        m_phase = P_FAIL;
                        m_cur   = 16'd0;
                    end else if (in_phase == m_delay * CPM) begin
                        m_phase = P_GO;
                        m_t0    = c + 1;
                    end
                end
                P_GO: begin
                    if (pr) begin
                        m_cur   = go_ms(c);
                        m_phase = P_DONE;
                        if (m_cur < m_best) m_best = m_cur;
                    end else if (in_phase == (MAXT + 1) * CPM) begin
                        m_phase = P_FAIL;
                        m_cur   = 16'(MAXT);
                    end
                end
                default: if (pr) enter_wait(c);
            endcase
            m_prev = btn;
            m_lfsr = lfsr_next(m_lfsr);
        end
        cyc++;
    endtask

    always @(posedge clk) model_step();

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Continuous comparison, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        check("cmp_led_go", 32'(led_go), 32'(m_phase == P_GO));
        check("cmp_fail", 32'(fail), 32'(m_phase == P_FAIL));
        check("cmp_current_time", 32'(current_time),
              32'((m_phase == P_GO) ? go_ms(cyc) : m_cur));
        check("cmp_best_time", 32'(best_time), 32'(m_best));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_btn();
        btn = 1'b1;
        step(1);
        btn = 1'b0;
    endtask

    // Press when the model LFSR promises a short delay, keeping each round brief.
    task automatic start_round();
        for (int i = 0; i < 4000 && (m_lfsr & 16'h0FFF) >= 16'd32; i++) step(1);
        press_btn();
    endtask

    task automatic wait_phase(input phase_e p, input string what);
        int n;
        n = 0;
        while (m_phase != p && n < 20000) begin
            step(1);
            n++;
        end
        check(what, 32'(m_phase == p), 32'd1);
    endtask

    initial begin
        // 1: reset and idle
        rst = 1'b1;
        btn = 1'b0;
        step(3);
        rst = 1'b0;
        step(10);
        check("idle_current_time", 32'(current_time), 32'd0);
        check("idle_best_time", 32'(best_time), 32'hFFFF);
        check("idle_fail", 32'(fail), 32'd0);
        check("idle_led_go", 32'(led_go), 32'd0);

        // 2: measured rounds of 3 ms and 5 ms
        start_round();
        wait_phase(P_GO, "r1_reach_go");
        check("r1_led_go_on", 32'(led_go), 32'd1);
        step(3 * CPM + 1);
        press_btn();
        check("r1_current_time", 32'(current_time), 32'd3);
        check("r1_best_time", 32'(best_time), 32'd3);
        check("r1_led_go_off", 32'(led_go), 32'd0);

        start_round();
        wait_phase(P_GO, "r2_reach_go");
        step(5 * CPM + 1);
        press_btn();
        check("r2_current_time", 32'(current_time), 32'd5);
        check("r2_best_time", 32'(best_time), 32'd3);

        // 3: early press, then press exactly on the expiry tick
        start_round();
        step(2);
        press_btn();
        check("early_fail", 32'(fail), 32'd1);
        check("early_current_time", 32'(current_time), 32'd0);
        check("early_best_time", 32'(best_time), 32'd3);

        start_round();
        step(int'(m_delay * CPM) - 1);
        press_btn();
        check("expiry_fail", 32'(fail), 32'd1);
        check("expiry_led_go", 32'(led_go), 32'd0);

        // 4: timeout, then press on the timeout tick
        start_round();
        wait_phase(P_GO, "to_reach_go");
        step(int'((MAXT + 1) * CPM) - 1);
        check("to_at_limit", 32'(current_time), 32'd20);
        check("to_not_failed_yet", 32'(fail), 32'd0);
        step(1);
        check("to_fail", 32'(fail), 32'd1);
        check("to_current_time", 32'(current_time), 32'd20);
        check("to_best_time", 32'(best_time), 32'd3);

        start_round();
        wait_phase(P_GO, "tp_reach_go");
        step(int'((MAXT + 1) * CPM) - 1);
        press_btn();
        check("tp_fail", 32'(fail), 32'd0);
        check("tp_current_time", 32'(current_time), 32'd20);
        check("tp_best_time", 32'(best_time), 32'd3);

        // 5: long hold in DONE starts exactly one round; reset mid-GO with button held
        for (int i = 0; i < 4000 && (m_lfsr & 16'h0FFF) >= 16'd32; i++) step(1);
        btn = 1'b1;
        step(50);
        btn = 1'b0;
        step(1);
        wait_phase(P_GO, "hold_reach_go");
        step(5);
        rst = 1'b1;
        btn = 1'b1;
        step(3);
        rst = 1'b0;
        step(5);
        check("rst_current_time", 32'(current_time), 32'd0);
        check("rst_best_time", 32'(best_time), 32'hFFFF);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_led_go", 32'(led_go), 32'd0);
        btn = 1'b0;
        step(2);

        start_round();
        wait_phase(P_GO, "post_rst_reach_go");
        step(2 * CPM + 1);
        press_btn();
        check("post_rst_current_time", 32'(current_time), 32'd2);
        check("post_rst_best_time", 32'(best_time), 32'd2);

        // zero-millisecond reaction is a valid record
        start_round();
        wait_phase(P_GO, "zero_reach_go");
        step(1);
        press_btn();
        check("zero_current_time", 32'(current_time), 32'd0);
        check("zero_best_time", 32'(best_time), 32'd0);
        check("zero_fail", 32'(fail), 32'd0);

        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
